muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It is the successor to the fixed 32-bit mult, div and hi/lo blocks in the multi-cycle MIPS datapath. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO through a start/busy/done handshake, so the control unit stalls on `busy` instead of counting cycles. It is generic in operand width and also reports divide-by-zero.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_absneg.sv | 13 +
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
// Op bit 1 selects divide, and a cleared bit 0 marks a signed op.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_absneg.sv
// Conditional two's-complement negate, used both for operand magnitudes
// and for the final sign fix-up of products, quotients and remainders.
module muldiv_absneg #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle radix-2 multiply/divide unit with architectural HI/LO registers
// and a start/busy/done handshake; one iteration per cycle on magnitudes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // mult: {partial, multiplier}; div: low half = dividend/quotient
    logic [WIDTH-1:0]   r_mcand;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_rem;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_busy;
    logic               r_done;
    logic               r_divz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_sgn;
    logic               w_div;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_sgn = op_is_signed(op);
    assign w_div = op_is_div(op);

    muldiv_absneg #(.WIDTH(WIDTH)) u_abs_a (
        .i_neg(w_sgn & a[WIDTH-1]), .i_val(a), .o_val(w_abs_a));
    muldiv_absneg #(.WIDTH(WIDTH)) u_abs_b (
        .i_neg(w_sgn & b[WIDTH-1]), .i_val(b), .o_val(w_abs_b));

    assign w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_mcand : '0)};
    // Restoring step: the shifted remainder needs one extra bit before the trial subtract.
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_mcand};

    muldiv_absneg #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_neg(r_neg_res), .i_val(r_acc), .o_val(w_prod_fix));
    muldiv_absneg #(.WIDTH(WIDTH)) u_fix_quo (
        .i_neg(r_neg_res), .i_val(r_acc[WIDTH-1:0]), .o_val(w_quo_fix));
    muldiv_absneg #(.WIDTH(WIDTH)) u_fix_rem (
        .i_neg(r_neg_rem), .i_val(r_rem), .o_val(w_rem_fix));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_rem     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divz    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            r_divz <= 1'b0;
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
            case (r_state)
                IDLE: if (start) begin
                    r_busy    <= 1'b1;
                    r_is_div  <= w_div;
                    r_mcand   <= w_div ? w_abs_b : w_abs_a;
                    r_acc     <= {{WIDTH{1'b0}}, (w_div ? w_abs_a : w_abs_b)};
                    r_rem     <= '0;
                    r_neg_res <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_neg_rem <= w_sgn & a[WIDTH-1];
                    r_cnt     <= CNT_W'(WIDTH);
                    if (w_div && (b == '0)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_divz  <= 1'b1;
                    end else begin
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_is_div) begin
                        if (!w_diff[WIDTH]) begin
                            r_rem             <= w_diff[WIDTH-1:0];
                            r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem             <= w_shift[WIDTH-1:0];
                            r_acc[WIDTH-1:0]  <= {r_acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= {w_madd, r_acc[WIDTH-1:1]};
                    end
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    // The committed result takes priority over a same-cycle MTHI/MTLO.
                    if (!r_divz) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_divz;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/div_zero are pushed at
// start and popped when done pulses; latency, busy and MTHI/MTLO priority checked.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t r;
        logic signed [63:0] sx, sy, sp;
        logic [63:0] ux, uy, up;
        sx = 64'($signed(x));
        sy = 64'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        r.dz = 1'b0;
        r.hi = '0;
        r.lo = '0;
        case (o)
            2'b00: begin sp = sx * sy; r.hi = sp[63:32]; r.lo = sp[31:0]; end
            2'b01: begin up = ux * uy; r.hi = up[63:32]; r.lo = up[31:0]; end
            2'b10: begin
                if (y == '0) r.dz = 1'b1;
                else begin
                    sp = sx / sy; r.lo = sp[31:0];
                    sp = sx % sy; r.hi = sp[31:0];
                end
            end
            default: begin
                if (y == '0) r.dz = 1'b1;
                else begin
                    up = ux / uy; r.lo = up[31:0];
                    up = ux % uy; r.hi = up[31:0];
                end
            end
        endcase
        return r;
    endfunction

    task automatic mthi(input logic [W-1:0] v);
        hi_we = 1'b1; wdata = v; tick; hi_we = 1'b0;
        m_hi = v;
        chk("mthi", 64'(hi), 64'(m_hi));
    endtask

    task automatic mtlo(input logic [W-1:0] v);
        lo_we = 1'b1; wdata = v; tick; lo_we = 1'b0;
        m_lo = v;
        chk("mtlo", 64'(lo), 64'(m_lo));
    endtask

    // ex_start > 0: extra start pulse in that busy cycle; -1: start in the DONE cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit mt_done, input int ex_start);
        exp_t e;
        exp_t g;
        int   n;
        e = model(o, x, y);
        sb.push_back(e);
        start = 1'b1; op = o; a = x; b = y;
        tick;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        n = 1;
        while (!done && n < 200) begin
            chk("busy_run", 64'(busy), 64'(1));
            if (ex_start == n) begin
                start = 1'b1; op = 2'b01; a = 32'h1234; b = 32'h5678;
            end
            tick;
            start = 1'b0;
            n++;
        end
        chk("latency", 64'(n), e.dz ? 64'(1) : 64'(W + 1));
        chk("busy_done", 64'(busy), 64'(1));
        if (sb.size() == 0) begin
            chk("sb_empty", 64'(1), 64'(0));
        end else begin
            g = sb.pop_front();
            chk("div_zero", 64'(div_zero), 64'(g.dz));
            if (mt_done) begin hi_we = 1'b1; wdata = 32'hDEAD; end
            if (ex_start == -1) begin start = 1'b1; op = 2'b01; a = 32'h3; b = 32'h3; end
            tick;
            hi_we = 1'b0; start = 1'b0;
            if (mt_done) m_hi = 32'hDEAD;
            if (!g.dz) begin m_hi = g.hi; m_lo = g.lo; end
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("busy_idle", 64'(busy), 64'(0));
            chk("done_low", 64'(done), 64'(0));
            chk("dz_low", 64'(div_zero), 64'(0));
        end
    endtask

    initial begin
        int n_done;
        logic [W-1:0] ry;

        reset = 1'b0;
        tick; tick;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        reset = 1'b1;
        tick;

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
        chk("tp_multu_hi", 64'(hi), 64'hFFFFFFFE);
        chk("tp_multu_lo", 64'(lo), 64'h00000001);
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, 0);
        chk("tp_mult_hi", 64'(hi), 64'hFFFFFFFF);
        chk("tp_mult_lo", 64'(lo), 64'hFFFFFFF1);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
        chk("tp_div_lo", 64'(lo), 64'hFFFFFFFD);
        chk("tp_div_hi", 64'(hi), 64'hFFFFFFFF);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
        chk("tp_ovf_lo", 64'(lo), 64'h80000000);
        chk("tp_ovf_hi", 64'(hi), 64'h0);

        mthi(32'h11);
        mtlo(32'h22);
        run_op(2'b11, 32'd123, 32'd0, 1'b0, 0);
        chk("tp_dz_hi", 64'(hi), 64'h11);
        chk("tp_dz_lo", 64'(lo), 64'h22);

        run_op(2'b01, 32'd7, 32'd9, 1'b0, 5);
        chk("tp_busy_start", 64'(lo), 64'd63);
        n_done = 0;
        repeat (5) begin tick; if (done) n_done++; end
        chk("no_extra_done", 64'(n_done), 64'(0));

        run_op(2'b01, 32'd2, 32'd3, 1'b1, 0);
        chk("tp_ovr_hi", 64'(hi), 64'h0);
        chk("tp_ovr_lo", 64'(lo), 64'h6);
        mthi(32'hDEAD);

        mthi(32'h0);
        run_op(2'b11, 32'd5, 32'd0, 1'b1, 0);
        chk("dz_mthi", 64'(hi), 64'hDEAD);

        run_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 1'b0, -1);
        tick;
        chk("start_in_done", 64'(busy), 64'(0));

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: ry = '0;
                1: ry = W'($urandom_range(1, 20));
                2: ry = -W'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            run_op(2'($urandom_range(0, 3)), $urandom, ry, 1'($urandom_range(0, 1)), 0);
        end

        mthi(32'h55);
        mtlo(32'h66);
        start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd9;
        tick;
        start = 1'b0;
        repeat (8) tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("rr_busy", 64'(busy), 64'(0));
        chk("rr_done", 64'(done), 64'(0));
        chk("rr_hi", 64'(hi), 64'(0));
        chk("rr_lo", 64'(lo), 64'(0));
        n_done = 0;
        repeat (40) begin tick; if (done || busy) n_done++; end
        chk("rr_abandon", 64'(n_done), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
